pipeline_run_controller: RTL and testbench

Sequences execution of the 5-stage MIPS pipeline on behalf of the debugger. It accepts run, step and abort commands and produces the single pipeline enable that gates the PC and every pipeline latch. On a HALT instruction or on reaching max PC, it drains the pipeline for a fixed number of cycles, then reports completion. It also counts executed cycles for the debugger to read out.

---
 rtl/pipeline_run_controller_pkg.sv | 24 ++
 rtl/pipeline_run_controller_if.sv | 28 ++
 rtl/pipeline_run_controller_sat_counter.sv | 27 ++
 rtl/pipeline_run_controller.sv | 105 ++++++++++
 tb/tb_pipeline_run_controller.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_run_controller_pkg.sv
// Shared encodings for the debugger-driven pipeline run controller.
package pipeline_run_controller_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_STEP  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_ABORT = 2'b11;

    localparam logic [1:0] RSN_NONE  = 2'b00;
    localparam logic [1:0] RSN_HALT  = 2'b01;
    localparam logic [1:0] RSN_MAXPC = 2'b10;
    localparam logic [1:0] RSN_ABORT = 2'b11;

    localparam logic [31:0] HALT_INSTR_DEF = 32'hFC000000;

endpackage

// File: rtl/pipeline_run_controller_if.sv
// Debugger/pipeline side signals of the run controller; master = debugger, slave = controller.
interface pipeline_run_controller_if #(
    parameter int SIZE      = 32,
    parameter int CNT_WIDTH = 32
);
    logic                 i_cmd_valid;
    logic [1:0]           i_cmd;
    logic                 o_cmd_ready;
    logic [SIZE-1:0]      i_instruction;
    logic [SIZE-1:0]      i_pc;
    logic [SIZE-1:0]      i_max_pc;
    logic                 i_ext_stall;
    logic                 o_pipe_enable;
    logic                 o_busy;
    logic                 o_done;
    logic [1:0]           o_halt_reason;
    logic [CNT_WIDTH-1:0] o_cycle_count;

    modport master (
        output i_cmd_valid, i_cmd, i_instruction, i_pc, i_max_pc, i_ext_stall,
        input  o_cmd_ready, o_pipe_enable, o_busy, o_done, o_halt_reason, o_cycle_count
    );

    modport slave (
        input  i_cmd_valid, i_cmd, i_instruction, i_pc, i_max_pc, i_ext_stall,
        output o_cmd_ready, o_pipe_enable, o_busy, o_done, o_halt_reason, o_cycle_count
    );
endinterface

// File: rtl/pipeline_run_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipeline_run_controller_sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr)
            cnt_d = '0;
        else if (i_inc && (cnt_q != '1))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign o_count = cnt_q;
endmodule

// File: rtl/pipeline_run_controller.sv
// Run/step/abort sequencer producing the global pipeline enable, with halt drain
// and a saturating count of enabled cycles.
module pipeline_run_controller
    import pipeline_run_controller_pkg::*;
#(
    parameter int              SIZE         = 32,
    parameter logic [SIZE-1:0] HALT_INSTR   = SIZE'(HALT_INSTR_DEF),
    parameter int              DRAIN_CYCLES = 4,
    parameter int              CNT_WIDTH    = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    pipeline_run_controller_if.slave  bus
);
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

    state_e        state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;
    logic [1:0]    reason_q, reason_d;
    logic          pipe_en, cmd_ready, accept, cnt_clr, is_halt, is_max;

    assign pipe_en   = ((state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_DRAIN))
                       && !bus.i_ext_stall;
    assign cmd_ready = (state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_DRAIN);
    assign accept    = bus.i_cmd_valid && cmd_ready;
    assign is_halt   = (bus.i_instruction == HALT_INSTR);
    assign is_max    = (bus.i_pc == bus.i_max_pc);

    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        reason_d = reason_q;
        cnt_clr  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept && (bus.i_cmd == CMD_RUN)) begin
                    state_d  = S_RUN;
                    reason_d = RSN_NONE;
                    cnt_clr  = 1'b1;
                end else if (accept && (bus.i_cmd == CMD_STEP)) begin
                    state_d  = S_STEP;
                    reason_d = RSN_NONE;
                end
            end
            S_STEP: begin
                if (pipe_en) begin
                    state_d  = S_DONE;
                    reason_d = RSN_ABORT;
                end
            end
            S_RUN: begin
                // Abort beats termination detected in the same cycle.
                if (accept && (bus.i_cmd == CMD_ABORT)) begin
                    state_d  = S_DONE;
                    reason_d = RSN_ABORT;
                end else if (pipe_en && (is_halt || is_max)) begin
                    reason_d = is_halt ? RSN_HALT : RSN_MAXPC;
                    if (DRAIN_CYCLES == 0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DRAIN;
                        drain_d = DW'(DRAIN_CYCLES);
                    end
                end
            end
            S_DRAIN: begin
                if (accept && (bus.i_cmd == CMD_ABORT)) begin
                    state_d  = S_DONE;
                    reason_d = RSN_ABORT;
                end else if (pipe_en) begin
                    drain_d = drain_q - DW'(1);
                    if (drain_q == DW'(1)) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            drain_q  <= '0;
            reason_q <= RSN_NONE;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            reason_q <= reason_d;
        end
    end

    pipeline_run_controller_sat_counter #(.W(CNT_WIDTH)) u_cycle_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (cnt_clr),
        .i_inc   (pipe_en),
        .o_count (bus.o_cycle_count)
    );

    assign bus.o_pipe_enable = pipe_en;
    assign bus.o_cmd_ready   = cmd_ready;
    assign bus.o_busy        = (state_q != S_IDLE);
    assign bus.o_done        = (state_q == S_DONE);
    assign bus.o_halt_reason = reason_q;
endmodule

// File: tb/tb_pipeline_run_controller.sv
// Bench for pipeline_run_controller: directed table, corner sequences, random vs. reference model.
module tb_pipeline_run_controller;
    localparam int          DRAIN = 4;
    localparam logic [31:0] HALT  = 32'hFC000000;
    localparam logic [1:0]  NOP = 2'b00, RUN = 2'b01, STEP = 2'b10, ABORT = 2'b11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_run_controller_if #(.SIZE(32), .CNT_WIDTH(32)) bus  ();
    pipeline_run_controller_if #(.SIZE(32), .CNT_WIDTH(4))  bus4 ();

    assign bus4.i_cmd_valid   = bus.i_cmd_valid;
    assign bus4.i_cmd         = bus.i_cmd;
    assign bus4.i_instruction = bus.i_instruction;
    assign bus4.i_pc          = bus.i_pc;
    assign bus4.i_max_pc      = bus.i_max_pc;
    assign bus4.i_ext_stall   = bus.i_ext_stall;

    pipeline_run_controller #(.SIZE(32), .HALT_INSTR(HALT), .DRAIN_CYCLES(DRAIN), .CNT_WIDTH(32)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus.slave));
    pipeline_run_controller #(.SIZE(32), .HALT_INSTR(HALT), .DRAIN_CYCLES(DRAIN), .CNT_WIDTH(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .bus(bus4.slave));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: activity flags plus remaining drain cycles.
    bit m_run, m_step, m_done;
    int m_drain, m_reason, m_count;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_active();
        return m_run || m_step || (m_drain > 0);
    endfunction

    task automatic check_model();
        bit exp_en;
        exp_en = m_active() && !bus.i_ext_stall;
        chk("pipe_enable", 32'(bus.o_pipe_enable), 32'(exp_en));
        chk("cmd_ready",   32'(bus.o_cmd_ready),   32'(!(m_step || m_done)));
        chk("busy",        32'(bus.o_busy),        32'(m_active() || m_done));
        chk("done",        32'(bus.o_done),        32'(m_done));
        chk("halt_reason", 32'(bus.o_halt_reason), m_reason);
        chk("cycle_count", bus.o_cycle_count,      m_count);
        chk("cycle_count_w4", 32'(bus4.o_cycle_count), (m_count > 15) ? 15 : m_count);
    endtask

    task automatic model_edge();
        bit en, acc, abort_cmd;
        en        = m_active() && !bus.i_ext_stall;
        acc       = bus.i_cmd_valid && !(m_step || m_done);
        abort_cmd = acc && (bus.i_cmd == ABORT);
        if (rst) begin
            m_run = 0; m_step = 0; m_done = 0; m_drain = 0; m_reason = 0; m_count = 0;
            return;
        end
        if (en) m_count++;
        if (m_done) begin
            m_done = 0;
        end else if (m_step) begin
            if (en) begin m_step = 0; m_done = 1; m_reason = 3; end
        end else if (m_run) begin
            if (abort_cmd) begin
                m_run = 0; m_done = 1; m_reason = 3;
            end else if (en && (bus.i_instruction == HALT || bus.i_pc == bus.i_max_pc)) begin
                m_run    = 0;
                m_reason = (bus.i_instruction == HALT) ? 1 : 2;
                m_drain  = DRAIN;
            end
        end else if (m_drain > 0) begin
            if (abort_cmd) begin
                m_drain = 0; m_done = 1; m_reason = 3;
            end else if (en) begin
                m_drain--;
                if (m_drain == 0) m_done = 1;
            end
        end else if (acc && bus.i_cmd == RUN) begin
            m_run = 1; m_count = 0; m_reason = 0;
        end else if (acc && bus.i_cmd == STEP) begin
            m_step = 1; m_reason = 0;
        end
    endtask

    // Inputs applied at negedge, outputs checked 1ns later, model advanced for the next posedge.
    task automatic cyc(input bit r, input bit v, input logic [1:0] c, input bit s,
                       input logic [31:0] ins, input logic [31:0] p);
        rst = r;
        bus.i_cmd_valid = v; bus.i_cmd = c; bus.i_ext_stall = s;
        bus.i_instruction = ins; bus.i_pc = p;
        #1;
        check_model();
    endtask

    task automatic adv();
        model_edge();
        @(negedge clk);
    endtask

    // Run from a fresh reset; k counts cycles after the run command, pc = 4*k.
    task automatic run_case(input string nm, input logic [31:0] maxpc, input int halt_k,
                            input int abort_k, input int exp_k, input int exp_cnt, input int exp_rsn);
        bit seen;
        seen = 0;
        bus.i_max_pc = maxpc;
        cyc(1, 0, NOP, 0, 0, 0); adv();
        cyc(0, 1, RUN, 0, 0, 0); adv();
        for (int k = 0; k < 40; k++) begin
            cyc(0, k == abort_k, (k == abort_k) ? ABORT : NOP, 0, (k == halt_k) ? HALT : 32'h0, 32'(4 * k));
            if (bus.o_done) begin
                chk({nm, "_done_cycle"}, k, exp_k);
                chk({nm, "_count"}, bus.o_cycle_count, exp_cnt);
                chk({nm, "_reason"}, 32'(bus.o_halt_reason), exp_rsn);
                seen = 1;
                adv();
                break;
            end
            adv();
        end
        if (!seen) chk({nm, "_done_timeout"}, 0, 1);
    endtask

    typedef struct {
        bit          v;
        logic [1:0]  c;
        logic [31:0] ins;
        bit          en;
        bit          done;
        bit          busy;
        logic [1:0]  rsn;
        int          cnt;
    } vec_t;
    vec_t tbl[11];

    initial begin
        int enables, dones;
        rst = 1;
        bus.i_cmd_valid = 0; bus.i_cmd = NOP; bus.i_ext_stall = 0;
        bus.i_instruction = 0; bus.i_pc = 0; bus.i_max_pc = 100;
        @(posedge clk);
        model_edge();
        @(negedge clk);

        // HALT on the 4th enabled cycle: 4 RUN + 4 DRAIN, then done.
        tbl[0] = '{1, RUN, 0,    0, 0, 0, 2'd0, 0};
        tbl[1] = '{0, NOP, 0,    1, 0, 1, 2'd0, 0};
        tbl[2] = '{0, NOP, 0,    1, 0, 1, 2'd0, 1};
        tbl[3] = '{0, NOP, 0,    1, 0, 1, 2'd0, 2};
        tbl[4] = '{0, NOP, HALT, 1, 0, 1, 2'd0, 3};
        tbl[5] = '{0, NOP, 0,    1, 0, 1, 2'd1, 4};
        tbl[6] = '{0, NOP, 0,    1, 0, 1, 2'd1, 5};
        tbl[7] = '{0, NOP, 0,    1, 0, 1, 2'd1, 6};
        tbl[8] = '{0, NOP, 0,    1, 0, 1, 2'd1, 7};
        tbl[9] = '{0, NOP, 0,    0, 1, 1, 2'd1, 8};
        tbl[10] = '{0, NOP, 0,   0, 0, 0, 2'd1, 8};
        for (int i = 0; i < 11; i++) begin
            cyc(0, tbl[i].v, tbl[i].c, 0, tbl[i].ins, 0);
            chk($sformatf("tbl%0d_en", i),     32'(bus.o_pipe_enable), 32'(tbl[i].en));
            chk($sformatf("tbl%0d_done", i),   32'(bus.o_done),        32'(tbl[i].done));
            chk($sformatf("tbl%0d_busy", i),   32'(bus.o_busy),        32'(tbl[i].busy));
            chk($sformatf("tbl%0d_reason", i), 32'(bus.o_halt_reason), 32'(tbl[i].rsn));
            chk($sformatf("tbl%0d_count", i),  bus.o_cycle_count,      tbl[i].cnt);
            adv();
        end

        run_case("maxpc",      12,   -1, -1, 8,  8,  2);
        run_case("halt_at_max", 12,   3, -1, 8,  8,  1);
        run_case("abort_drain", 1000, 2,  4, 5,  5,  3);
        run_case("saturate",   1000, -1, 19, 20, 20, 3);
        chk("saturate_w4", 32'(bus4.o_cycle_count), 15);

        // Reset in the middle of a run.
        cyc(0, 1, RUN, 0, 0, 0); adv();
        for (int i = 0; i < 3; i++) begin cyc(0, 0, NOP, 0, 0, 0); adv(); end
        cyc(1, 0, NOP, 0, 0, 0); adv();
        cyc(0, 0, NOP, 0, 0, 0);
        chk("midrst_busy",  32'(bus.o_busy), 0);
        chk("midrst_en",    32'(bus.o_pipe_enable), 0);
        chk("midrst_count", bus.o_cycle_count, 0);
        chk("midrst_done",  32'(bus.o_done), 0);
        adv();

        // Two single steps, the second stalled for 3 cycles.
        enables = 0; dones = 0;
        for (int s = 0; s < 2; s++) begin
            cyc(0, 1, STEP, 0, 0, 0); adv();
            for (int j = 0; j < 6; j++) begin
                cyc(0, 0, NOP, (s == 1) && (j < 3), 0, 0);
                enables += int'(bus.o_pipe_enable);
                dones   += int'(bus.o_done);
                adv();
            end
        end
        chk("step_enables", enables, 2);
        chk("step_dones",   dones, 2);
        chk("step_count",   bus.o_cycle_count, 2);
        chk("step_reason",  32'(bus.o_halt_reason), 3);

        // Random traffic against the model.
        bus.i_max_pc = 12;
        for (int i = 0; i < 1500; i++) begin
            logic [1:0]  c;
            logic [31:0] ins;
            c   = 2'($urandom_range(0, 3));
            ins = ($urandom_range(0, 19) == 0) ? HALT : 32'($urandom);
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 3, c,
                $urandom_range(0, 3) == 0, ins, 32'(4 * $urandom_range(0, 4)));
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
